// File: rtl/seg_display_pkg.sv
// Shared types, segment patterns and BCD helpers for the
// multiplexed seven-segment display path.
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    // Bit order {dp,g,f,e,d,c,b,a}, active-high.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    function automatic logic [3:0] bcd_adj3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] r;
        r = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nib == 4'(i)) begin
                r = SEG_DIGIT[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_display_conv.sv
// Sequential double-dabble converter: one shift per clock,
// flags any BCD carry lost off the top digit.
module bcd_seq_converter
    import seg_display_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     value,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = bcd_adj3(bcd_q[4*k +: 4]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (start) begin
            bin_q <= value;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
            ovf_q <= 1'b0;
        end else if (cnt_q != '0) begin
            bin_q <= {bin_q[DATA_W-2:0], 1'b0};
            bcd_q <= {adj[BCD_W-2:0], bin_q[DATA_W-1]};
            ovf_q <= ovf_q | adj[BCD_W-1];
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // High during the final iteration so the caller can step on.
    assign done    = (cnt_q == CNT_W'(1));
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/seg_scan_display.sv
// Binary-to-BCD display driver: accept handshake, sticky ALU
// status LEDs and a time-multiplexed seven-segment scanner.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIGITS     = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_zero,
    input  logic              in_overflow,
    input  logic              in_carry,
    input  logic              blank_lz,
    input  logic              leds_clear,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] digit_en,
    output logic [1:0]        leds,
    output logic              busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0] SEG_INV =
        (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] EN_INV =
        (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              conv_done;
    logic              conv_ovf;
    logic [DATA_W-1:0] conv_value;
    logic [BCD_W-1:0]  conv_bcd;
    logic [BCD_W-1:0]  disp_q;
    logic              range_err_q;
    logic [1:0]        leds_q;
    logic [PRE_W-1:0]  pre_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DIGITS-1:0] lz;
    logic              zrun;
    logic [DIGITS-1:0] en_d;
    logic [DIGITS-1:0] en_q;
    logic [7:0]        seg_d;
    logic [7:0]        seg_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CONVERT;
            CONVERT: if (conv_done) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        accept   = (state_q == IDLE) && in_valid;
    end

    assign conv_value = in_zero ? '0 : in_value;

    bcd_seq_converter #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (accept),
        .value   (conv_value),
        .done    (conv_done),
        .bcd_out (conv_bcd),
        .ovf     (conv_ovf)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_q      <= '0;
            range_err_q <= 1'b0;
        end else if (state_q == UPDATE) begin
            disp_q      <= conv_bcd;
            range_err_q <= conv_ovf;
        end
    end

    // A flag arriving with an accept beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leds_q <= 2'b00;
        end else begin
            leds_q[0] <= (accept & in_overflow)
                       | (leds_q[0] & ~leds_clear);
            leds_q[1] <= (accept & in_carry)
                       | (leds_q[1] & ~leds_clear);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // lz[i]: digit i and everything above it are zero.
    always_comb begin
        zrun = 1'b1;
        lz   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun  = zrun & (disp_q[4*i +: 4] == 4'd0);
            lz[i] = zrun;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        en_d  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                en_d[i] = 1'b1;
                if (range_err_q) begin
                    seg_d = SEG_DASH;
                end else if (blank_lz && (i > 0) && lz[i]) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = seg_decode(disp_q[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= SEG_INV;
            en_q  <= EN_INV;
        end else begin
            seg_q <= seg_d ^ SEG_INV;
            en_q  <= en_d ^ EN_INV;
        end
    end

    assign seg      = seg_q;
    assign digit_en = en_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a default build and a 2-digit
// active-low build share stimulus against a value-level model.
module tb_seg_scan_display;

    localparam int DW = 8;
    localparam int D1 = 3;
    localparam int S1 = 1000;
    localparam int D2 = 2;
    localparam int S2 = 4;

    localparam logic [7:0] PAT [10] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_value = '0;
    logic          in_zero = 1'b0;
    logic          in_overflow = 1'b0;
    logic          in_carry = 1'b0;
    logic          blank_lz = 1'b0;
    logic          leds_clear = 1'b0;

    logic          rdy1, rdy2, busy1, busy2;
    logic [7:0]    seg1, seg2;
    logic [D1-1:0] en1;
    logic [D2-1:0] en2;
    logic [1:0]    leds1, leds2;

    always #5 clock = ~clock;

    seg_scan_display #(
        .DATA_W(DW), .DIGITS(D1), .SCAN_DIV(S1), .ACTIVE_LOW(0)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_value(in_value), .in_zero(in_zero),
        .in_overflow(in_overflow), .in_carry(in_carry),
        .blank_lz(blank_lz), .leds_clear(leds_clear),
        .seg(seg1), .digit_en(en1), .leds(leds1), .busy(busy1)
    );

    seg_scan_display #(
        .DATA_W(DW), .DIGITS(D2), .SCAN_DIV(S2), .ACTIVE_LOW(1)
    ) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(rdy2),
        .in_value(in_value), .in_zero(in_zero),
        .in_overflow(in_overflow), .in_carry(in_carry),
        .blank_lz(blank_lz), .leds_clear(leds_clear),
        .seg(seg2), .digit_en(en2), .leds(leds2), .busy(busy2)
    );

    int n_pass = 0;
    int n_total = 0;

    // Model: m_ec counts edges since reset, m_left is remaining busy cycles.
    int            m_ec, m_left, m_pend, m_disp;
    logic [1:0]    m_leds;
    logic [7:0]    m_seg1, m_seg2;
    logic [D1-1:0] m_en1;
    logic [D2-1:0] m_en2;

    function automatic int p10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] exp_pat(int val, int nd, logic blz, int idx, bit al);
        logic [7:0] r;
        if (val >= p10(nd)) r = 8'h40;
        else if (blz && idx > 0 && val < p10(idx)) r = 8'h00;
        else r = PAT[(val / p10(idx)) % 10];
        return al ? ~r : r;
    endfunction

    function automatic logic [7:0] exp_en(int idx, int nd, bit al);
        logic [7:0] r;
        r = 8'(1 << idx);
        if (al) r = r ^ 8'((1 << nd) - 1);
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ec   <= 0;
            m_left <= 0;
            m_pend <= 0;
            m_disp <= 0;
            m_leds <= 2'b00;
            m_seg1 <= 8'h00;
            m_en1  <= '0;
            m_seg2 <= 8'hFF;
            m_en2  <= '1;
        end else begin
            m_ec   <= m_ec + 1;
            m_seg1 <= exp_pat(m_disp, D1, blank_lz, (m_ec / S1) % D1, 1'b0);
            m_en1  <= D1'(exp_en((m_ec / S1) % D1, D1, 1'b0));
            m_seg2 <= exp_pat(m_disp, D2, blank_lz, (m_ec / S2) % D2, 1'b1);
            m_en2  <= D2'(exp_en((m_ec / S2) % D2, D2, 1'b1));
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_disp <= m_pend;
            end else if (in_valid) begin
                m_left <= DW + 1;
                m_pend <= in_zero ? 0 : int'(in_value);
            end
            m_leds[0] <= (m_left == 0 && in_valid && in_overflow) ? 1'b1
                       : (leds_clear ? 1'b0 : m_leds[0]);
            m_leds[1] <= (m_left == 0 && in_valid && in_carry) ? 1'b1
                       : (leds_clear ? 1'b0 : m_leds[1]);
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("seg1", 32'(seg1), 32'(m_seg1));
        chk("en1", 32'(en1), 32'(m_en1));
        chk("leds1", 32'(leds1), 32'(m_leds));
        chk("busy1", 32'(busy1), 32'(m_left != 0));
        chk("ready1", 32'(rdy1), 32'(m_left == 0));
        chk("seg2", 32'(seg2), 32'(m_seg2));
        chk("en2", 32'(en2), 32'(m_en2));
        chk("leds2", 32'(leds2), 32'(m_leds));
        chk("busy2", 32'(busy2), 32'(m_left != 0));
        chk("ready2", 32'(rdy2), 32'(m_left == 0));
    endtask

    task automatic step();
        @(negedge clock);
        check_all();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (rdy1 !== 1'b1 && g < 40) begin
            step();
            g++;
        end
        chk("wait_idle", 32'(g < 40), 32'd1);
    endtask

    task automatic accept(int v, bit z, bit o, bit c);
        wait_idle();
        in_valid    = 1'b1;
        in_value    = DW'(v);
        in_zero     = z;
        in_overflow = o;
        in_carry    = c;
        step();
        in_valid    = 1'b0;
        in_zero     = 1'b0;
        in_overflow = 1'b0;
        in_carry    = 1'b0;
    endtask

    task automatic wait_en(logic [D1-1:0] target);
        int g = 0;
        while (en1 !== target && g < 4000) begin
            step();
            g++;
        end
        chk("wait_en", 32'(g < 4000), 32'd1);
    endtask

    initial begin
        int cnt;

        run(3);
        chk("rst_seg1", 32'(seg1), 32'h00);
        chk("rst_en2", 32'(en2), 32'h3);
        reset_n = 1'b1;

        accept(205, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (busy1 === 1'b1 && cnt < 50) begin
            cnt++;
            step();
        end
        chk("busy_len", 32'(cnt), 32'd9);
        step();
        wait_en(3'b001);
        chk("d205_u", 32'(seg1), 32'h6D);
        wait_en(3'b010);
        chk("d205_t", 32'(seg1), 32'h3F);
        cnt = 0;
        while (en1 === 3'b010 && cnt < 2000) begin
            cnt++;
            step();
        end
        chk("hold_len", 32'(cnt), 32'd1000);
        wait_en(3'b100);
        chk("d205_h", 32'(seg1), 32'h5B);

        blank_lz = 1'b1;
        accept(7, 1'b0, 1'b0, 1'b0);
        run(20);
        wait_en(3'b100);
        chk("d7_blank_h", 32'(seg1), 32'h00);
        wait_en(3'b010);
        chk("d7_blank_t", 32'(seg1), 32'h00);
        wait_en(3'b001);
        chk("d7_u", 32'(seg1), 32'h07);
        blank_lz = 1'b0;
        step();
        wait_en(3'b100);
        chk("d7_noblank_h", 32'(seg1), 32'h3F);

        accept(150, 1'b0, 1'b0, 1'b0);
        run(20);
        chk("d150_dash", 32'(seg2), 32'hBF);
        run(10);
        chk("d150_dash2", 32'(seg2), 32'hBF);
        accept(99, 1'b0, 1'b0, 1'b0);
        run(20);
        chk("d99_a", 32'(seg2), 32'h90);
        run(4);
        chk("d99_b", 32'(seg2), 32'h90);

        blank_lz = 1'b1;
        accept(37, 1'b1, 1'b1, 1'b0);
        chk("leds_ovf", 32'(leds1), 32'h1);
        run(20);
        wait_en(3'b001);
        chk("dz_u", 32'(seg1), 32'h3F);
        wait_en(3'b010);
        chk("dz_t", 32'(seg1), 32'h00);
        accept(55, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("leds_sticky", 32'(leds1), 32'h1);
        leds_clear = 1'b1;
        step();
        leds_clear = 1'b0;
        chk("leds_clr", 32'(leds1), 32'h0);
        wait_idle();
        leds_clear = 1'b1;
        accept(12, 1'b0, 1'b0, 1'b1);
        leds_clear = 1'b0;
        chk("leds_setwins", 32'(leds2), 32'h2);

        wait_idle();
        in_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            in_value = DW'($urandom_range(0, 255));
            step();
            if (rdy1 === 1'b1) cnt++;
        end
        in_valid = 1'b0;
        chk("cont_accepts", 32'(cnt), 32'd4);

        for (int i = 0; i < 20; i++) begin
            blank_lz   = 1'($urandom_range(0, 1));
            leds_clear = 1'($urandom_range(0, 1));
            accept(int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            leds_clear = 1'b0;
            run(int'($urandom_range(0, 15)));
        end
        run(3010);

        blank_lz = 1'b1;
        accept(200, 1'b0, 1'b1, 1'b1);
        run(3);
        reset_n = 1'b0;
        #1;
        chk("arst_seg1", 32'(seg1), 32'h00);
        chk("arst_en1", 32'(en1), 32'h0);
        chk("arst_seg2", 32'(seg2), 32'hFF);
        chk("arst_en2", 32'(en2), 32'h3);
        chk("arst_leds", 32'(leds1), 32'h0);
        chk("arst_busy", 32'(busy1), 32'h0);
        chk("arst_ready", 32'(rdy1), 32'h1);
        step();
        reset_n = 1'b1;
        run(30);
        chk("rst0_busy", 32'(busy1), 32'h0);
        wait_en(3'b001);
        chk("rst0_u", 32'(seg1), 32'h3F);
        wait_en(3'b100);
        chk("rst0_h", 32'(seg1), 32'h00);
        while (en2 !== 2'b10) step();
        chk("rst0_u2", 32'(seg2), 32'hC0);
        run(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
